// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, the NOP
// used for out-of-range fetches, FSM encoding and the FIFO entry layout.
package instruction_fetch_unit_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          ENTRY_W   = XLEN * 2 + 1;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush. Flush dominates push and pop in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  input  logic                           i_flush,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // A pop frees a slot in the same cycle, so push into a full FIFO is legal with pop.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer, occupancy and storage update; flush empties without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational instruction
// memory, buffers {pc, instr, fault} toward decode and handles redirects.
// Fetching past the end of memory enqueues a faulting NOP and halts until redirected.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  output logic        misalign_err
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

  fetch_state_t  r_state;
  logic [31:0]   r_fpc;
  logic          r_misalign;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_out_of_range;
  fetch_entry_t  w_wentry;
  fetch_entry_t  w_head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] w_count;

  assign imem_addr      = r_fpc;
  assign misalign_err   = r_misalign;
  assign w_out_of_range = (r_fpc >= IMEM_LIMIT);
  assign w_pop          = ~w_empty & if_ready & ~redirect_valid;
  assign w_push         = (r_state == ST_FETCH) & (~w_full | w_pop) & ~redirect_valid;

  // Build the entry to enqueue: out-of-range fetches become a faulting NOP.
  always_comb begin
    w_wentry.pc = r_fpc;
    if (w_out_of_range) begin
      w_wentry.instr = INSTR_NOP;
      w_wentry.fault = 1'b1;
    end else begin
      w_wentry.instr = imem_instr;
      w_wentry.fault = 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Present the head entry to decode; all fields read zero while empty.
  always_comb begin
    if_valid = ~w_empty;
    if (w_empty) begin
      if_pc    = 32'h0000_0000;
      if_instr = 32'h0000_0000;
      if_fault = 1'b0;
    end else begin
      if_pc    = w_head.pc;
      if_instr = w_head.instr;
      if_fault = w_head.fault;
    end
  end

  // Fetch PC, FETCH/HALT state and misalign pulse; redirect overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc      <= RESET_PC;
      r_state    <= ST_FETCH;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_fpc      <= align_word(redirect_pc);
      r_state    <= ST_FETCH;
      r_misalign <= (redirect_pc[1:0] != 2'b00);
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (w_push && w_out_of_range) begin
            r_state <= ST_HALT;
          end else if (w_push) begin
            r_fpc <= r_fpc + 32'd4;
          end else begin
            r_fpc <= r_fpc;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// ready/redirect traffic, all compared against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam int          WORDS  = 64;
  localparam logic [31:0] LIMIT  = 32'd256;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic        misalign_err;

  logic [31:0] mem [WORDS];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  ent_t        m_q[$];
  logic [31:0] m_fpc;
  logic        m_halted;
  logic        m_mis;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < LIMIT) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH),
    .IMEM_WORDS (WORDS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault),
    .misalign_err   (misalign_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc    = 32'h0;
    m_halted = 1'b0;
    m_mis    = 1'b0;
  endtask

  // One clock of the specification's rules, evaluated with the inputs of that cycle.
  task automatic model_step(input logic redir, input logic [31:0] rpc, input logic rdy);
    bit   pop;
    int   size_before;
    ent_t e;
    size_before = m_q.size();
    pop = (size_before > 0) && rdy;
    if (redir) begin
      m_q.delete();
      m_fpc    = rpc & 32'hFFFF_FFFC;
      m_halted = 1'b0;
      m_mis    = (rpc % 4) != 0;
    end else begin
      m_mis = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (!m_halted && (size_before < DEPTH || pop)) begin
        if (m_fpc >= LIMIT) begin
          e = '{pc: m_fpc, instr: NOP, fault: 1'b1};
          m_halted = 1'b1;
        end else begin
          e = '{pc: m_fpc, instr: mem[m_fpc / 4], fault: 1'b0};
          m_fpc = m_fpc + 32'd4;
        end
        m_q.push_back(e);
      end
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    check_eq("if_valid",     {31'b0, if_valid},     {31'b0, m_q.size() > 0});
    check_eq("if_pc",        if_pc,                 h.pc);
    check_eq("if_instr",     if_instr,              h.instr);
    check_eq("if_fault",     {31'b0, if_fault},     {31'b0, h.fault});
    check_eq("imem_addr",    imem_addr,             m_fpc);
    check_eq("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  // Called at a negedge: drive, step through the posedge, check at the next negedge.
  task automatic do_cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
    redirect_valid = redir;
    redirect_pc    = rpc;
    if_ready       = rdy;
    @(posedge clk);
    model_step(redir, rpc, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    model_reset();

    // 1: reset state then streaming from RESET_PC
    repeat (2) @(negedge clk);
    check_eq("rst_if_valid",  {31'b0, if_valid}, 32'h0);
    check_eq("rst_imem_addr", imem_addr, 32'h0);
    check_eq("rst_if_pc",     if_pc, 32'h0);
    check_eq("rst_if_instr",  if_instr, 32'h0);
    check_eq("rst_misalign",  {31'b0, misalign_err}, 32'h0);
    rst_n = 1'b1;
    do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("first_pc", if_pc, 32'h0);
    check_eq("first_instr", if_instr, mem[0]);
    repeat (2) do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("third_pc", if_pc, 32'h8);

    // 2: backpressure from a fresh start
    do_cycle(1'b1, 32'h0, 1'b0);
    repeat (5) do_cycle(1'b0, 32'h0, 1'b0);
    check_eq("bp_addr", imem_addr, 32'h8);
    check_eq("bp_head", if_pc, 32'h0);
    repeat (4) do_cycle(1'b0, 32'h0, 1'b1);

    // 3: redirect with full FIFO, then redirect coincident with a pop
    repeat (3) do_cycle(1'b0, 32'h0, 1'b0);
    do_cycle(1'b1, 32'h20, 1'b0);
    check_eq("redir_empty", {31'b0, if_valid}, 32'h0);
    do_cycle(1'b0, 32'h0, 1'b0);
    check_eq("redir_pc", if_pc, 32'h20);
    do_cycle(1'b1, 32'h40, 1'b1);
    repeat (3) do_cycle(1'b0, 32'h0, 1'b1);

    // 4: misaligned redirect
    do_cycle(1'b1, 32'h22, 1'b1);
    check_eq("mis_pulse", {31'b0, misalign_err}, 32'h1);
    check_eq("mis_addr", imem_addr, 32'h20);
    do_cycle(1'b0, 32'h0, 1'b0);
    check_eq("mis_clear", {31'b0, misalign_err}, 32'h0);
    check_eq("mis_pc", if_pc, 32'h20);

    // 5: run off the end of memory, stay halted, resume on redirect
    do_cycle(1'b1, 32'hF8, 1'b1);
    repeat (10) do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("halt_addr", imem_addr, 32'h100);
    do_cycle(1'b1, 32'h0, 1'b1);
    repeat (3) do_cycle(1'b0, 32'h0, 1'b1);

    // 6: async reset while two entries are held
    repeat (4) do_cycle(1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_valid", {31'b0, if_valid}, 32'h0);
    check_eq("arst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("arst_first_pc", if_pc, 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic        rd;
      logic [31:0] rp;
      rd = ($urandom_range(0, 15) == 0);
      rp = $urandom_range(0, 32'h110);
      do_cycle(rd, rp, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
